ula_exec_stage: RTL and testbench

Execute stage that sits directly upstream of the `ula` combinational ALU and consumes its result. It holds the 4-entry operand register bank and accepts an issued instruction `{op, ra, rb}` over a valid/ready handshake. It drives the ALU's `a_in`/`b_in`/`op_in` from registered operands and writes `result_out` back into `ra`, REDUX-V style (`ra = ra op rb`). It reports each completed result downstream over a second valid/ready handshake, and provides a load-path write port and a debug read port.

---
 rtl/ula_exec_stage.sv | 132 +++++++++++++
 tb/tb_ula_exec_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_exec_stage.sv
// rtl/ula_exec_stage.sv - execute stage driving the ula ALU with a register bank and writeback
//
// Holds a REGS-entry operand bank and runs one ALU operation per issued instruction
// {op, ra, rb}, writing the ALU result back into ra (ra = ra op rb).
//
// Ports:
//   clk_in, rst_n_in                     clock, synchronous active-low reset
//   issue_valid_in / issue_ready_out     instruction handshake
//   issue_op_in, issue_ra_in, issue_rb_in  opcode, dest/first operand, second operand
//   ula_a_out, ula_b_out, ula_op_out     operands to the ALU (meaningful in EXEC only)
//   ula_result_in                        combinational result from the ALU
//   wr_valid_in, wr_addr_in, wr_data_in  load-path register write
//   done_valid_out / done_ready_in       completion handshake
//   done_addr_out, done_data_out         register written and its new value
//   rd_addr_in, rd_data_out              combinational debug read
//   busy_out                             high whenever an operation is in flight
module ula_exec_stage #(
    parameter int BITS = 8,
    parameter int OP   = 4,
    parameter int REGS = 4,
    parameter int AW   = $clog2(REGS)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            issue_valid_in,
    output logic            issue_ready_out,
    input  logic [OP-1:0]   issue_op_in,
    input  logic [AW-1:0]   issue_ra_in,
    input  logic [AW-1:0]   issue_rb_in,
    output logic [BITS-1:0] ula_a_out,
    output logic [BITS-1:0] ula_b_out,
    output logic [OP-1:0]   ula_op_out,
    input  logic [BITS-1:0] ula_result_in,
    input  logic            wr_valid_in,
    input  logic [AW-1:0]   wr_addr_in,
    input  logic [BITS-1:0] wr_data_in,
    output logic            done_valid_out,
    input  logic            done_ready_in,
    output logic [AW-1:0]   done_addr_out,
    output logic [BITS-1:0] done_data_out,
    input  logic [AW-1:0]   rd_addr_in,
    output logic [BITS-1:0] rd_data_out,
    output logic            busy_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [BITS-1:0] regs [REGS];
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    logic [OP-1:0]   op_q;
    logic [AW-1:0]   dest_q;
    logic [BITS-1:0] res_q;

    logic            accept;
    logic            in_exec;
    logic [BITS-1:0] ra_val;
    logic [BITS-1:0] rb_val;

    // A new instruction may enter while the previous result is being taken,
    // which gives one instruction every two cycles under no backpressure.
    assign issue_ready_out = (state == S_IDLE) || ((state == S_DONE) && done_ready_in);
    assign accept          = issue_valid_in && issue_ready_out;
    assign in_exec         = (state == S_EXEC);

    // Issue can only be accepted in IDLE or DONE, where no ALU writeback is
    // pending, so only the load-path write needs forwarding into the operands.
    assign ra_val = (wr_valid_in && (wr_addr_in == issue_ra_in)) ? wr_data_in : regs[issue_ra_in];
    assign rb_val = (wr_valid_in && (wr_addr_in == issue_rb_in)) ? wr_data_in : regs[issue_rb_in];

    assign ula_a_out      = a_q;
    assign ula_b_out      = b_q;
    assign ula_op_out     = op_q;
    assign done_valid_out = (state == S_DONE);
    assign done_addr_out  = dest_q;
    assign done_data_out  = res_q;
    assign rd_data_out    = regs[rd_addr_in];
    assign busy_out       = (state != S_IDLE);

    // Register bank: the ALU writeback is assigned last so it wins a
    // same-address collision with the load path.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_valid_in) begin
                regs[wr_addr_in] <= wr_data_in;
            end
            if (in_exec) begin
                regs[dest_q] <= ula_result_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            dest_q <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q    <= ra_val;
                        b_q    <= rb_val;
                        op_q   <= issue_op_in;
                        dest_q <= issue_ra_in;
                        state  <= S_EXEC;
                    end else if (state == S_DONE && done_ready_in) begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    res_q <= ula_result_in;
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_exec_stage.sv
// tb/tb_ula_exec_stage.sv - self-checking bench for ula_exec_stage with an ALU stand-in
module tb_ula_exec_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ivalid = 1'b0;
    logic       iready;
    logic [3:0] iop = '0;
    logic [1:0] ira = '0;
    logic [1:0] irb = '0;
    logic [7:0] ula_a, ula_b, ula_res;
    logic [3:0] ula_op;
    logic       wvalid = 1'b0;
    logic [1:0] wa = '0;
    logic [7:0] wd = '0;
    logic       dvalid;
    logic       dready = 1'b1;
    logic [1:0] daddr;
    logic [7:0] ddata;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a ^ b;
            4'd4:    return a | b;
            default: return a;
        endcase
    endfunction

    assign ula_res = alu(ula_a, ula_b, ula_op);

    ula_exec_stage dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .issue_valid_in(ivalid), .issue_ready_out(iready),
        .issue_op_in(iop), .issue_ra_in(ira), .issue_rb_in(irb),
        .ula_a_out(ula_a), .ula_b_out(ula_b), .ula_op_out(ula_op), .ula_result_in(ula_res),
        .wr_valid_in(wvalid), .wr_addr_in(wa), .wr_data_in(wd),
        .done_valid_out(dvalid), .done_ready_in(dready),
        .done_addr_out(daddr), .done_data_out(ddata),
        .rd_addr_in(rd_addr), .rd_data_out(rd_data), .busy_out(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase 0 = no operation, 1 = ALU evaluating, 2 = result offered.
    logic [7:0] m_reg [4] = '{default: 8'h00};
    logic [7:0] m_a = '0, m_b = '0, m_res = '0;
    logic [3:0] m_op = '0;
    logic [1:0] m_dest = '0;
    int         m_ph = 0;
    logic       started = 1'b0;

    always @(posedge clk) begin : mdl
        logic [7:0] nr [4];
        logic       rdy;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] <= 8'h00;
            m_a <= '0; m_b <= '0; m_op <= '0; m_dest <= '0; m_res <= '0;
            m_ph <= 0;
            started <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) nr[i] = m_reg[i];
            if (wvalid) nr[wa] = wd;
            if (m_ph == 1) nr[m_dest] = alu(m_a, m_b, m_op);
            for (int i = 0; i < 4; i++) m_reg[i] <= nr[i];
            rdy = (m_ph == 0) || (m_ph == 2 && dready);
            if (ivalid && rdy) begin
                m_a    <= (wvalid && wa == ira) ? wd : m_reg[ira];
                m_b    <= (wvalid && wa == irb) ? wd : m_reg[irb];
                m_op   <= iop;
                m_dest <= ira;
                m_ph   <= 1;
            end else if (m_ph == 1) begin
                m_res <= alu(m_a, m_b, m_op);
                m_ph  <= 2;
            end else if (m_ph == 2 && dready) begin
                m_ph <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_ready", iready, (m_ph == 0) || (m_ph == 2 && dready));
            chk("cmp_busy", busy, m_ph != 0);
            chk("cmp_dvalid", dvalid, m_ph == 2);
            chk("cmp_rd", rd_data, m_reg[rd_addr]);
            chk("cmp_ula_a", ula_a, m_a);
            chk("cmp_ula_b", ula_b, m_b);
            chk("cmp_ula_op", ula_op, m_op);
            if (m_ph == 2) begin
                chk("cmp_daddr", daddr, m_dest);
                chk("cmp_ddata", ddata, m_res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wvalid = 1'b1; wa = a; wd = d;
        tick();
        wvalid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_ready", iready, 1'b1);
        chk("rst_dvalid", dvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ula_a", ula_a, 8'h00);
        chk("rst_ula_op", ula_op, 4'h0);
        chk("rst_ddata", ddata, 8'h00);
        chk("rst_daddr", daddr, 2'd0);
        for (int i = 0; i < 4; i++) rd_chk("rst_rd", 2'(i), 8'h00);
        rst_n = 1'b1;
        tick();

        // Basic XOR: r0 = 0x5A ^ 0xFF
        wr(2'd0, 8'h5A);
        wr(2'd1, 8'hFF);
        ivalid = 1'b1; iop = 4'd3; ira = 2'd0; irb = 2'd1;
        tick();
        ivalid = 1'b0;
        chk("xor_ula_a", ula_a, 8'h5A);
        chk("xor_ula_b", ula_b, 8'hFF);
        tick();
        chk("xor_dvalid", dvalid, 1'b1);
        chk("xor_daddr", daddr, 2'd0);
        chk("xor_ddata", ddata, 8'hA5);
        rd_chk("xor_rd0", 2'd0, 8'hA5);
        chk("model_r0", m_reg[0], 8'hA5);
        tick();

        // Backpressure: r0 = 0xA5 ^ 0xFF = 0x5A held, pending add r1,r1 waits
        dready = 1'b0;
        ivalid = 1'b1; iop = 4'd3; ira = 2'd0; irb = 2'd1;
        tick();
        iop = 4'd0; ira = 2'd1; irb = 2'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_dvalid", dvalid, 1'b1);
            chk("bp_ddata", ddata, 8'h5A);
            chk("bp_daddr", daddr, 2'd0);
            chk("bp_ready", iready, 1'b0);
            tick();
        end
        dready = 1'b1;
        #1;
        chk("bp_ready_release", iready, 1'b1);
        tick();
        ivalid = 1'b0;
        chk("bp_next_ula_a", ula_a, 8'hFF);
        chk("bp_next_busy", busy, 1'b1);
        tick();
        chk("bp_next_ddata", ddata, 8'hFE);
        chk("bp_next_daddr", daddr, 2'd1);
        tick();

        // Back-to-back: 0x0F ^ 0xF0 = 0xFF, then 0xFF ^ 0xF0 = 0x0F
        wr(2'd0, 8'h0F);
        wr(2'd1, 8'hF0);
        ivalid = 1'b1; iop = 4'd3; ira = 2'd0; irb = 2'd1;
        tick();
        tick();
        chk("b2b_first", ddata, 8'hFF);
        chk("b2b_ready_in_done", iready, 1'b1);
        tick();
        ivalid = 1'b0;
        chk("b2b_fwd_ula_a", ula_a, 8'hFF);
        tick();
        chk("b2b_second", ddata, 8'h0F);
        chk("b2b_second_valid", dvalid, 1'b1);
        tick();

        // Bypass on issue, then a dropped load write to the destination during EXEC
        wr(2'd2, 8'h11);
        ivalid = 1'b1; iop = 4'd3; ira = 2'd2; irb = 2'd3;
        wvalid = 1'b1; wa = 2'd3; wd = 8'h33;
        tick();
        ivalid = 1'b0;
        chk("byp_ula_b", ula_b, 8'h33);
        wa = 2'd2; wd = 8'h77;
        tick();
        wvalid = 1'b0;
        chk("byp_ddata", ddata, 8'h22);
        rd_chk("coll_rd2", 2'd2, 8'h22);
        rd_chk("byp_rd3", 2'd3, 8'h33);
        tick();

        // Different-address writes during EXEC both land
        ivalid = 1'b1; iop = 4'd4; ira = 2'd1; irb = 2'd2;
        tick();
        ivalid = 1'b0;
        wvalid = 1'b1; wa = 2'd0; wd = 8'hC3;
        tick();
        wvalid = 1'b0;
        rd_chk("dual_rd0", 2'd0, 8'hC3);
        rd_chk("dual_rd1", 2'd1, 8'hF2);
        tick();

        // Reset mid-operation: add r3,r3 discarded
        ivalid = 1'b1; iop = 4'd0; ira = 2'd3; irb = 2'd3;
        tick();
        ivalid = 1'b0;
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_dvalid", dvalid, 1'b0);
        chk("mid_busy_after", busy, 1'b0);
        chk("mid_ready", iready, 1'b1);
        rd_chk("mid_rd3", 2'd3, 8'h00);
        tick();
        chk("mid_dvalid_later", dvalid, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
